// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, FSM state encoding and requester indices for the data-memory arbiter
package dmem_pkg;
  localparam int ADDR_W_D = 5;
  localparam int DATA_W_D = 32;
  localparam int REQ_CORE = 0;
  localparam int REQ_LDR = 1;
  typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;
endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// dmem_arb_starve_cnt: saturating count of consecutive denied loader cycles
module dmem_arb_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] cnt,
  output logic       sat
);
  assign sat = cnt == 4'(LIMIT);
  // clear on grant, count denied cycles up to the limit, hold otherwise
  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !sat) cnt <= cnt + 4'd1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core/loader arbiter for the data memory port; DMEM_ARB_STATS_EN adds conflict_cnt
module dmem_arbiter import dmem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int STARVE_LIMIT = 4
`ifdef DMEM_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic              ldr_lock,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_rvalid,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
  , output logic [CNT_W-1:0] conflict_cnt
`endif
);
  state_t state, state_n;
  logic [1:0] gnt;
  logic [3:0] wait_cnt;
  logic sat, core_gnt;
  dmem_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .CLK(CLK), .RST(RST), .inc(ldr_req & ~ldr_gnt), .clr(ldr_gnt), .cnt(wait_cnt), .sat(sat)
  );
  // grants are suppressed while RST is high so a write in a reset cycle never reaches memory
  always_comb begin
    gnt = '0;
    gnt[REQ_LDR] = ~RST & ldr_req & (state == S_LOCK | ~core_req | sat);
    gnt[REQ_CORE] = ~RST & core_req & (state == S_IDLE) & ~gnt[REQ_LDR];
    state_n = state == S_IDLE ? (gnt[REQ_LDR] & ldr_lock ? S_LOCK : S_IDLE) : (ldr_lock ? S_LOCK : S_IDLE);
  end
  assign core_gnt = gnt[REQ_CORE];
  assign ldr_gnt = gnt[REQ_LDR];
  assign core_stall = core_req & ~core_gnt;
  assign core_rdata = core_gnt ? mem_rd : '0;
  assign mem_a = core_gnt ? core_addr : ldr_gnt ? ldr_addr : '0;
  assign mem_we = core_gnt ? core_we : ldr_gnt & ldr_we;
  assign mem_wd = core_gnt ? core_wdata : ldr_gnt ? ldr_wdata : '0;
  // lock state register
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= S_IDLE;
    else state <= state_n;
  // capture loader read data one cycle after its grant
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      ldr_rdata <= '0;
      ldr_rvalid <= 1'b0;
    end else begin
      ldr_rvalid <= ldr_gnt & ~ldr_we;
      if (ldr_gnt && !ldr_we) ldr_rdata <= mem_rd;
    end
`ifdef DMEM_ARB_STATS_EN
  // saturating count of cycles where both requesters want the port
  always_ff @(posedge CLK or posedge RST)
    if (RST) conflict_cnt <= '0;
    else if (core_req && ldr_req && !(&conflict_cnt)) conflict_cnt <= conflict_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a 32x32 memory model
module tb_dmem_arbiter;
  logic CLK = 1'b0, RST = 1'b1;
  logic core_req, core_we, ldr_req, ldr_we, ldr_lock, core_stall, ldr_gnt, ldr_rvalid, mem_we;
  logic [4:0] core_addr, ldr_addr, mem_a;
  logic [31:0] core_wdata, core_rdata, ldr_wdata, ldr_rdata, mem_wd, mem_rd;
  logic [31:0] mem [32];
  int errors = 0, checks = 0;
`ifdef DMEM_ARB_STATS_EN
  logic [3:0] conflict_cnt;
`endif
  dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(4)
`ifdef DMEM_ARB_STATS_EN
    , .CNT_W(4)
`endif
  ) dut (
    .CLK(CLK), .RST(RST),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rdata(ldr_rdata), .ldr_rvalid(ldr_rvalid),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );
  always #5 CLK = ~CLK;
  assign mem_rd = mem[mem_a];
  always @(posedge CLK) if (mem_we) mem[mem_a] <= mem_wd;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic cr, input logic cw, input logic [4:0] ca, input logic [31:0] cd,
                       input logic lr, input logic lw, input logic ll, input logic [4:0] la,
                       input logic [31:0] ld);
    @(negedge CLK);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    ldr_req = lr; ldr_we = lw; ldr_lock = ll; ldr_addr = la; ldr_wdata = ld;
    #1;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_stall", core_stall, 0);
    chk("rst_gnt", ldr_gnt, 0);
    chk("rst_rvalid", ldr_rvalid, 0);
    chk("rst_rdata", ldr_rdata, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_we", mem_we, 0);
    RST = 1'b0;
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0);
    chk("core3_stall", core_stall, 0);
    chk("core3_mem_a", mem_a, 3);
    drive(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    chk("cw_stall", core_stall, 0);
    chk("cw_mem_we", mem_we, 1);
    chk("cw_mem_wd", mem_wd, 32'hDEADBEEF);
    drive(1, 0, 5, 0, 0, 0, 0, 0, 0);
    chk("cr_rdata", core_rdata, 32'hDEADBEEF);
    chk("cr_stall", core_stall, 0);
    drive(0, 0, 0, 0, 1, 1, 0, 31, 32'h12345678);
    chk("lw_gnt", ldr_gnt, 1);
    chk("lw_mem_we", mem_we, 1);
    chk("lw_mem_a", mem_a, 31);
    drive(0, 0, 0, 0, 1, 0, 0, 31, 0);
    chk("lr_gnt", ldr_gnt, 1);
    chk("lr_mem_we", mem_we, 0);
    chk("lr_rvalid_pre", ldr_rvalid, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lr_rvalid", ldr_rvalid, 1);
    chk("lr_rdata", ldr_rdata, 32'h12345678);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lr_rvalid_drop", ldr_rvalid, 0);
    chk("lr_rdata_hold", ldr_rdata, 32'h12345678);
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 5, 0, 1, 0, 0, 31, 0);
      chk($sformatf("cont%0d_gnt", i), ldr_gnt, 32'(i == 4));
      chk($sformatf("cont%0d_stall", i), core_stall, 32'(i == 4));
      chk($sformatf("cont%0d_mem_a", i), mem_a, i == 4 ? 31 : 5);
      chk($sformatf("cont%0d_rvalid", i), ldr_rvalid, 32'(i == 5));
    end
    for (int k = 0; k < 7; k++) begin
      logic lr, cr;
      logic [4:0] a;
      lr = k != 3;
      cr = k != 0;
      a = k < 3 ? 5'(k) : 5'(k - 1);
      drive(cr, 0, 7, 0, lr, 1, 1, a, 32'd100 + 32'(a));
      chk($sformatf("lock%0d_gnt", k), ldr_gnt, 32'(lr));
      chk($sformatf("lock%0d_stall", k), core_stall, 32'(cr));
      chk($sformatf("lock%0d_mem_we", k), mem_we, 32'(lr));
    end
    drive(1, 0, 7, 0, 0, 0, 0, 0, 0);
    chk("unlock_stall", core_stall, 1);
    chk("unlock_gnt", ldr_gnt, 0);
    drive(1, 0, 4, 0, 0, 0, 0, 0, 0);
    chk("post_lock_stall", core_stall, 0);
    chk("post_lock_rdata", core_rdata, 32'd104);
    drive(0, 0, 0, 0, 1, 1, 1, 9, 32'hAA);
    chk("rlock_gnt", ldr_gnt, 1);
    drive(0, 0, 0, 0, 1, 1, 1, 10, 32'hBB);
    RST = 1'b1;
    #1;
    chk("midrst_gnt", ldr_gnt, 0);
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_rvalid", ldr_rvalid, 0);
    chk("midrst_rdata", ldr_rdata, 0);
    @(posedge CLK);
    #2 RST = 1'b0;
    drive(1, 0, 10, 0, 0, 0, 0, 0, 0);
    chk("rel_stall", core_stall, 0);
    chk("rel_mem_a", mem_a, 10);
    chk("rel_discard", core_rdata, 0);
    drive(1, 0, 9, 0, 0, 0, 0, 0, 0);
    chk("rel_kept", core_rdata, 32'hAA);
`ifdef DMEM_ARB_STATS_EN
    for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("stats10", conflict_cnt, 10);
    for (int i = 0; i < 8; i++) drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("stats_sat", conflict_cnt, 15);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
